audio_adc_rx: RTL

- Receive-side counterpart of the codec DAC serializer: captures the codec's ADC serial stream (ADCDAT) framed by ADCLRC/BCLK and deserializes it into signed left/right samples.
- The codec is bus master, configured for I2S format with 24-bit word length. BCLK and ADCLRC are inputs here; all logic runs on sys_clk, with the serial pins oversampled.
- Completed stereo pairs are presented on a valid/ready handshake toward the sound sink.

---
 rtl/audio_adc_rx.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/audio_adc_rx.sv
`timescale 1ns/1ps
// audio_adc_rx
// Deserializes a codec ADC stream (I2S framing, codec is bus master) into
// signed left/right samples and hands complete stereo pairs to a sink.
// The serial pins are oversampled on sys_clk, which must run at least 4x bclk.
//
// Ports:
//   sys_clk, reset       system clock, asynchronous active-low reset
//   bclk, adclrc, adcdat codec bit clock, frame clock (0=left, 1=right), data
//   data_left/right      held stereo pair (raw two's complement)
//   sample_valid/ready   pair handshake toward the sink
//   overrun, overrun_clr sticky "pair dropped" flag and its clear
//   frame_err            one-cycle pulse when a channel ends before its word is full
//
// state     | meaning
// WAIT_LRC  | out of reset, waiting for the first frame-clock edge to align
// SKIP      | frame-clock edge seen; the edge rise carried the I2S delay bit
// SHIFT     | shifting data bits in, MSB first
// IDLE_TAIL | word complete, ignoring padding bits until the next edge
module audio_adc_rx #(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  bclk,
    input  logic                  adclrc,
    input  logic                  adcdat,
    output logic [DATA_WIDTH-1:0] data_left,
    output logic [DATA_WIDTH-1:0] data_right,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        WAIT_LRC  = 2'd0,
        SKIP      = 2'd1,
        SHIFT     = 2'd2,
        IDLE_TAIL = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lrc_sync_q, lrc_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   bclk_prev_q, bclk_prev_d;
    logic                   lrc_prev_q, lrc_prev_d;
    logic                   lrc_seen_q, lrc_seen_d;
    logic                   chan_q, chan_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DATA_WIDTH-2:0]  shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]  left_buf_q, left_buf_d;
    logic                   left_ok_q, left_ok_d;
    logic [DATA_WIDTH-1:0]  data_left_q, data_left_d;
    logic [DATA_WIDTH-1:0]  data_right_q, data_right_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic                   bclk_s, lrc_s, dat_s;
    logic                   rise, lrc_edge;
    logic [DATA_WIDTH-1:0]  word;
    logic                   word_done, pair_done, drop;

    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk};
        lrc_sync_d  = {lrc_sync_q[SYNC_STAGES-2:0], adclrc};
        dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], adcdat};
        bclk_s      = bclk_sync_q[SYNC_STAGES-1];
        lrc_s       = lrc_sync_q[SYNC_STAGES-1];
        dat_s       = dat_sync_q[SYNC_STAGES-1];

        bclk_prev_d = bclk_s;
        rise        = bclk_s & ~bclk_prev_q;
        // The first rise after reset only records the frame-clock level, so a
        // frame clock that is already high at release is not mistaken for an edge.
        lrc_edge    = rise & lrc_seen_q & (lrc_s != lrc_prev_q);
        lrc_prev_d  = rise ? lrc_s : lrc_prev_q;
        lrc_seen_d  = lrc_seen_q | rise;

        word        = {shreg_q, dat_s};

        state_d     = state_q;
        chan_d      = chan_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        left_buf_d  = left_buf_q;
        left_ok_d   = left_ok_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        pair_done   = 1'b0;

        if (lrc_edge) begin
            chan_d = lrc_s;
        end

        case (state_q)
            WAIT_LRC: begin
                if (lrc_edge) begin
                    state_d = SKIP;
                end
            end
            SKIP: begin
                // The edge rise already consumed the delay bit; the next rise is the MSB.
                if (lrc_edge) begin
                    frame_err_d = 1'b1;
                    left_ok_d   = 1'b0;
                end else begin
                    state_d = SHIFT;
                    count_d = '0;
                end
            end
            SHIFT: begin
                if (lrc_edge) begin
                    frame_err_d = 1'b1;
                    left_ok_d   = 1'b0;
                    state_d     = SKIP;
                end else if (rise) begin
                    shreg_d = word[DATA_WIDTH-2:0];
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(DATA_WIDTH - 1)) begin
                        word_done = 1'b1;
                        count_d   = '0;
                        state_d   = IDLE_TAIL;
                    end
                end
            end
            IDLE_TAIL: begin
                if (lrc_edge) begin
                    state_d = SKIP;
                end
            end
            default: begin
                state_d = WAIT_LRC;
            end
        endcase

        if (word_done) begin
            if (!chan_q) begin
                left_buf_d = word;
                left_ok_d  = 1'b1;
            end else if (left_ok_q) begin
                pair_done = 1'b1;
                left_ok_d = 1'b0;
            end
        end

        data_left_d  = data_left_q;
        data_right_d = data_right_q;
        valid_d      = valid_q;
        drop         = 1'b0;
        if (pair_done) begin
            if (!valid_q || sample_ready) begin
                data_left_d  = left_buf_q;
                data_right_d = word;
                valid_d      = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_LRC;
            bclk_sync_q  <= '0;
            lrc_sync_q   <= '0;
            dat_sync_q   <= '0;
            bclk_prev_q  <= 1'b0;
            lrc_prev_q   <= 1'b0;
            lrc_seen_q   <= 1'b0;
            chan_q       <= 1'b0;
            count_q      <= '0;
            shreg_q      <= '0;
            left_buf_q   <= '0;
            left_ok_q    <= 1'b0;
            data_left_q  <= '0;
            data_right_q <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bclk_sync_q  <= bclk_sync_d;
            lrc_sync_q   <= lrc_sync_d;
            dat_sync_q   <= dat_sync_d;
            bclk_prev_q  <= bclk_prev_d;
            lrc_prev_q   <= lrc_prev_d;
            lrc_seen_q   <= lrc_seen_d;
            chan_q       <= chan_d;
            count_q      <= count_d;
            shreg_q      <= shreg_d;
            left_buf_q   <= left_buf_d;
            left_ok_q    <= left_ok_d;
            data_left_q  <= data_left_d;
            data_right_q <= data_right_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_left    = data_left_q;
    assign data_right   = data_right_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;

endmodule
